// File: rtl/inst_sequencer.sv
// Instruction sequencer: fetches one byte per instruction and holds the PC, carry flag and link register.
// Latency: 2 clocks (inst[7]=0) or 3 clocks (inst[7]=1) at zero wait; imem_valid holds FETCH, stall freezes EXEC0/EXEC1.
module inst_sequencer #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [7:0]        imem_data,
    input  logic              imem_valid,
    input  logic              stall,
    output logic [7:0]        inst,
    output logic              cycle,
    output logic              ncycle,
    output logic              carry,
    output logic              exec,
    input  logic              carry_in,
    input  logic              WC,
    input  logic              J,
    input  logic              LJ,
    input  logic              nLJR,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC0 = 2'd1,
        EXEC1 = 2'd2
    } seqState_t;

    seqState_t         state, stateNext;
    logic [ADDR_W-1:0] pcReg, pcNext;
    logic [ADDR_W-1:0] linkReg, linkNext;
    logic [7:0]        instReg, instNext;
    logic              cycleReg, cycleNext;
    logic              carryReg, carryNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pcReg    <= RESET_PC;
            instReg  <= 8'h00;
            cycleReg <= 1'b0;
            carryReg <= 1'b0;
            linkReg  <= '0;
        end else begin
            state    <= stateNext;
            pcReg    <= pcNext;
            instReg  <= instNext;
            cycleReg <= cycleNext;
            carryReg <= carryNext;
            linkReg  <= linkNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pcReg;
        instNext  = instReg;
        cycleNext = cycleReg;
        carryNext = carryReg;
        linkNext  = linkReg;
        case (state)
            FETCH: begin
                if (imem_valid) begin
                    instNext  = imem_data;
                    pcNext    = pcReg + ADDR_W'(1);
                    stateNext = EXEC0;
                end
            end
            EXEC0: begin
                if (!stall) begin
                    if (WC)
                        carryNext = carry_in;
                    // pc already points past this instruction, which is the return address
                    if (LJ && !nLJR)
                        linkNext = pcReg;
                    if (instReg[7]) begin
                        stateNext = EXEC1;
                        cycleNext = 1'b1;
                    end else begin
                        stateNext = FETCH;
                    end
                end
            end
            EXEC1: begin
                if (!stall) begin
                    if (WC)
                        carryNext = carry_in;
                    if (J)
                        pcNext = jump_target;
                    stateNext = FETCH;
                    cycleNext = 1'b0;
                end
            end
            default: begin
                stateNext = FETCH;
                cycleNext = 1'b0;
            end
        endcase
    end

    assign imem_addr = pcReg;
    assign imem_req  = (state == FETCH);
    assign exec      = (state == EXEC0) || (state == EXEC1);
    assign pc        = pcReg;
    assign inst      = instReg;
    assign cycle     = cycleReg;
    assign ncycle    = ~cycleReg;
    assign carry     = carryReg;
    assign link      = linkReg;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: fetch waits, jumps, PC wrap, link, stalled carry and reset abort.
module tb_inst_sequencer;

    logic        clk;
    logic        rst;
    logic [15:0] imemAddr;
    logic        imemReq;
    logic [7:0]  imemData;
    logic        imemValid;
    logic        stall;
    logic [7:0]  inst;
    logic        cycle;
    logic        ncycle;
    logic        carry;
    logic        exec;
    logic        carryIn;
    logic        wc;
    logic        j;
    logic        lj;
    logic        nLjr;
    logic [15:0] jumpTarget;
    logic [15:0] pc;
    logic [15:0] link;

    int checkCnt = 0;
    int errCnt   = 0;

    inst_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imemAddr),
        .imem_req    (imemReq),
        .imem_data   (imemData),
        .imem_valid  (imemValid),
        .stall       (stall),
        .inst        (inst),
        .cycle       (cycle),
        .ncycle      (ncycle),
        .carry       (carry),
        .exec        (exec),
        .carry_in    (carryIn),
        .WC          (wc),
        .J           (j),
        .LJ          (lj),
        .nLJR        (nLjr),
        .jump_target (jumpTarget),
        .pc          (pc),
        .link        (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then sit on the falling edge for sampling and driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        imemData   = 8'h00;
        imemValid  = 1'b0;
        stall      = 1'b0;
        carryIn    = 1'b0;
        wc         = 1'b0;
        j          = 1'b0;
        lj         = 1'b0;
        nLjr       = 1'b1;
        jumpTarget = 16'h0000;
        @(negedge clk);
        step();

        // reset state
        checkVal("rst_pc",      32'(pc),       32'h0);
        checkVal("rst_inst",    32'(inst),     32'h00);
        checkVal("rst_cycle",   32'(cycle),    32'h0);
        checkVal("rst_ncycle",  32'(ncycle),   32'h1);
        checkVal("rst_carry",   32'(carry),    32'h0);
        checkVal("rst_link",    32'(link),     32'h0);
        checkVal("rst_exec",    32'(exec),     32'h0);
        checkVal("rst_req",     32'(imemReq),  32'h1);
        checkVal("rst_addr",    32'(imemAddr), 32'h0);

        // 0x41 with imem_valid held off for 3 cycles
        rst = 1'b0;
        imemData = 8'h41;
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("wait_exec", 32'(exec),     32'h0);
            checkVal("wait_addr", 32'(imemAddr), 32'h0);
        end
        imemValid = 1'b1;
        step();
        imemValid = 1'b0;
        checkVal("f41_inst",  32'(inst),  32'h41);
        checkVal("f41_exec",  32'(exec),  32'h1);
        checkVal("f41_cycle", 32'(cycle), 32'h0);
        checkVal("f41_pc",    32'(pc),    32'h1);
        step();
        checkVal("f41_back_fetch", 32'(imemReq),  32'h1);
        checkVal("f41_next_addr",  32'(imemAddr), 32'h1);

        // 0xE0: link in EXEC0, J ignored in EXEC0, taken in EXEC1
        imemData  = 8'hE0;
        imemValid = 1'b1;
        step();
        imemValid  = 1'b0;
        checkVal("fe0_cycle0", 32'(cycle), 32'h0);
        checkVal("fe0_pc",     32'(pc),    32'h2);
        lj         = 1'b1;
        nLjr       = 1'b0;
        j          = 1'b1;
        jumpTarget = 16'h1234;
        step();
        lj   = 1'b0;
        nLjr = 1'b1;
        checkVal("fe0_cycle1", 32'(cycle),  32'h1);
        checkVal("fe0_ncycle", 32'(ncycle), 32'h0);
        checkVal("fe0_exec1",  32'(exec),   32'h1);
        checkVal("fe0_noj0",   32'(pc),     32'h2);
        checkVal("fe0_link",   32'(link),   32'h2);
        step();
        j = 1'b0;
        checkVal("fe0_jaddr",  32'(imemAddr), 32'h1234);
        checkVal("fe0_req",    32'(imemReq),  32'h1);
        checkVal("fe0_cycleo", 32'(cycle),    32'h0);

        // jump to 0xFFFF so the next fetch wraps
        imemData  = 8'h80;
        imemValid = 1'b1;
        step();
        imemValid = 1'b0;
        step();
        j = 1'b1;
        jumpTarget = 16'hFFFF;
        step();
        j = 1'b0;
        checkVal("top_addr", 32'(imemAddr), 32'hFFFF);
        imemData  = 8'h10;
        imemValid = 1'b1;
        step();
        imemValid = 1'b0;
        checkVal("wrap_pc", 32'(pc), 32'h0);
        lj   = 1'b1;
        nLjr = 1'b0;
        step();
        lj   = 1'b0;
        nLjr = 1'b1;
        checkVal("wrap_link",  32'(link), 32'h0);
        checkVal("wrap_fetch", 32'(exec), 32'h0);

        // carry write held off by a 2-cycle stall in EXEC0
        imemData  = 8'h90;
        imemValid = 1'b1;
        step();
        imemValid = 1'b0;
        wc      = 1'b1;
        carryIn = 1'b1;
        stall   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checkVal("stall_carry", 32'(carry), 32'h0);
            checkVal("stall_cycle", 32'(cycle), 32'h0);
            checkVal("stall_exec",  32'(exec),  32'h1);
        end
        stall = 1'b0;
        step();
        wc      = 1'b0;
        carryIn = 1'b0;
        checkVal("post_carry", 32'(carry), 32'h1);
        checkVal("post_cycle", 32'(cycle), 32'h1);

        // stalled jump does not commit, then reset aborts it
        j          = 1'b1;
        jumpTarget = 16'h0055;
        stall      = 1'b1;
        step();
        checkVal("sj_pc",    32'(pc),    32'h1);
        checkVal("sj_cycle", 32'(cycle), 32'h1);
        stall = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        j   = 1'b0;
        checkVal("abort_pc",    32'(pc),      32'h0);
        checkVal("abort_exec",  32'(exec),    32'h0);
        checkVal("abort_req",   32'(imemReq), 32'h1);
        checkVal("abort_cycle", 32'(cycle),   32'h0);
        checkVal("abort_carry", 32'(carry),   32'h0);
        checkVal("abort_inst",  32'(inst),    32'h00);

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Instruction sequencer and architectural-state holder that sits directly upstream of the `control` decoder. It fetches one instruction byte per instruction from instruction memory and holds it in the instruction register. It generates the two-phase `cycle`/`ncycle` execution strobe and owns the program counter, the carry flag and the link register. `control` consumes `inst`, `cycle`, `ncycle` and `carry` from this block. This block consumes `J`, `LJ`, `nLJR` and `WC` back from `control`.

## Interface
Parameters:
- `ADDR_W`, default 16: program counter / instruction address width.
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock. One clock domain; all state updates on rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `imem_addr`  out  ADDR_W  fetch address; always equals `pc`.
- `imem_req`  out  1  fetch request; high only in state FETCH.
- `imem_data`  in  8  fetched instruction byte.
- `imem_valid`  in  1  `imem_data` is valid this cycle.
- `stall`  in  1  datapath/memory busy; freezes the EXEC states.
- `inst`  out  8  instruction register, to `control.inst`.
- `cycle`  out  1  execution phase, to `control.cycle`.
- `ncycle`  out  1  always `~cycle`.
- `carry`  out  1  carry flag, to `control.carry`.
- `exec`  out  1  `inst`/`cycle` are valid for execution; register-file and memory writes are gated by it.
- `carry_in`  in  1  new carry from the ALU.
- `WC`  in  1  write carry, from `control`.
- `J`  in  1  jump taken, from `control`.
- `LJ`  in  1  link/jump-class instruction, from `control`.
- `nLJR`  in  1  active-low load of the link register, from `control`.
- `jump_target`  in  ADDR_W  jump destination from the register pair.
- `pc`  out  ADDR_W  program counter.
- `link`  out  ADDR_W  link register (return address).

## Operation
- States:
  - FETCH: `exec`=0.
  - EXEC0: `exec`=1, `cycle`=0.
  - EXEC1: `exec`=1, `cycle`=1.
- Reset (`rst`=1 on an edge) takes priority over `stall`, `imem_valid` and all control inputs. It sets:
  - state to FETCH
  - `pc` to RESET_PC, `inst` to 0x00, `cycle` to 0, `carry` to 0, `link` to 0
  - `exec` to 0, `imem_req` to 1
- FETCH:
  - Hold until `imem_valid`=1.
  - On the edge: `inst` <= `imem_data`, `pc` <= `pc`+1 modulo 2^ADDR_W, go to EXEC0.
- EXEC0:
  - If `stall`, hold all state.
  - Otherwise:
    - If `WC`: `carry` <= `carry_in`.
    - If `LJ` & ~`nLJR`: `link` <= `pc`. This is the already-incremented address.
    - If `inst[7]`=1: go to EXEC1 with `cycle` <= 1. Otherwise go to FETCH.
- EXEC1:
  - If `stall`, hold.
  - Otherwise:
    - If `WC`: `carry` <= `carry_in`.
    - If `J`: `pc` <= `jump_target`.
    - Go to FETCH with `cycle` <= 0.
- `J` is sampled only in EXEC1. `LJ` and `nLJR` are sampled only in EXEC0. `imem_valid` is ignored outside FETCH.
- Instructions with `inst[7]`=0 take 2 clocks (FETCH + EXEC0). Instructions with `inst[7]`=1 take 3 clocks. Zero-wait memory is assumed for these counts; each FETCH wait cycle and each stall cycle adds one clock.
- Carry written in EXEC0 is visible to `control` during EXEC1 of the same instruction.

## Timing
- All outputs are registered, or decoded from registered state only: `exec`, `imem_req` and `ncycle` come from state. There are no combinational input-to-output paths.
- `imem_addr`/`imem_req` are stable throughout FETCH. Memory may return `imem_valid` in the first cycle of FETCH, or any number of cycles later.
- PC wrap: 2^ADDR_W-1 increments to 0. A jump to any value, including the current `pc`, is legal.
- A jump in EXEC1 overrides the increment already applied in FETCH. The next FETCH address is `jump_target`.
- `stall` asserted in the same cycle as `WC` or `J`: neither takes effect until the cycle in which `stall` is low.
- `rst` asserted mid-instruction (EXEC0/EXEC1, stalled or not) aborts it; no pending carry, link or PC update commits.

## Test plan
- Reset → `pc`=0, `inst`=0x00, `cycle`=0, `carry`=0, `link`=0, `exec`=0, `imem_req`=1, `imem_addr`=0.
- Fetch 0x41 at addr 0 with `imem_valid` delayed 3 cycles → `inst`=0x41 after the 4th FETCH cycle; one EXEC0 cycle with `cycle`=0; then FETCH at `pc`=1.
- Fetch 0xE0 with `J`=1 in EXEC1 and `jump_target`=0x1234 → EXEC0 then EXEC1 (`cycle`=1); next `imem_addr`=0x1234.
- `pc`=0xFFFF, fetch 0x10 → `pc` wraps to 0x0000. With `LJ`=1, `nLJR`=0 in EXEC0 → `link`=0x0000.
- Two-cycle instruction with `WC`=1, `carry_in`=1 in EXEC0 while `stall`=1 for 2 cycles → `carry` stays 0 until `stall` drops, then becomes 1. EXEC1 follows with `carry`=1.
- `rst` in EXEC1 with `J`=1 → `pc`=RESET_PC (not `jump_target`), state FETCH.
